// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter and transfer sequencer that shares one spi_shift engine between NREQ requesters.
// Build option: define SPI_XFER_AUTO_SS_EN to drive ss_n from the grant instead of ss_manual.
module spi_xfer_arb #(
   parameter int NREQ  = 2,
   parameter int DIV_W = 8
) (
   input  logic                  clk_shift,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*5-1:0]     cfg_len,
   input  logic [NREQ-1:0]       cfg_lsb,
   input  logic [NREQ-1:0]       cfg_rxneg,
   input  logic [NREQ-1:0]       cfg_txneg,
   input  logic [NREQ*DIV_W-1:0] cfg_div,
   input  logic [NREQ*32-1:0]    wdata,
   input  logic [NREQ-1:0]       ss_manual,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [31:0]           rdata,
   output logic                  busy,
   output logic [NREQ-1:0]       ss_n,
   output logic [3:0]            sh_latch,
   output logic [31:0]           sh_byte_sel,
   output logic [31:0]           sh_p_in,
   output logic [4:0]            sh_len,
   output logic                  sh_lsb,
   output logic                  sh_rx_negedge,
   output logic                  sh_tx_negedge,
   output logic                  sh_go,
   output logic                  sh_pos_edge,
   output logic                  sh_neg_edge,
   output logic                  s_clk,
   input  logic                  sh_tip,
   input  logic [31:0]           sh_p_out,
   output logic [2:0]            dbg_state
);

   // Handshake: req[i] is a level held until done[i]; done[i] is a one-cycle pulse and
   // rdata is valid from that cycle until the next completion. gnt[i] is held LOAD..DONE.

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GO    = 3'd2,
      S_RUN   = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       sel_q, sel_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [4:0]          len_q, len_d;
   logic                lsb_q, lsb_d;
   logic                rxneg_q, rxneg_d;
   logic                txneg_q, txneg_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DIV_W-1:0]    dcnt_q, dcnt_d;
   logic                sclk_q, sclk_d;
   logic                pos_q, pos_d;
   logic                neg_q, neg_d;
   logic                tip_q, tip_d;
   logic                tip_seen_q, tip_seen_d;
   logic [2:0]          wd_q, wd_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [NREQ-1:0]     ss_n_q, ss_n_d;

   logic                win_found;
   logic [IW-1:0]       win_idx;
   logic [IW-1:0]       cand_idx;
   int                  cand;
   int                  wi;
   logic                tip_fall;
   logic                div_step;

   // Round-robin search starting at ptr_q and wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = cand[IW-1:0];
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign tip_fall = tip_q & ~sh_tip;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      len_d      = len_q;
      lsb_d      = lsb_q;
      rxneg_d    = rxneg_q;
      txneg_d    = txneg_q;
      div_d      = div_q;
      dcnt_d     = div_q;
      sclk_d     = 1'b0;
      pos_d      = 1'b0;
      neg_d      = 1'b0;
      tip_d      = sh_tip;
      tip_seen_d = tip_seen_q;
      wd_d       = wd_q;
      rdata_d    = rdata_q;
      div_step   = 1'b0;
      wi         = int'(win_idx);

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               sel_d          = win_idx;
               ptr_d          = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               len_d          = cfg_len[wi*5 +: 5];
               lsb_d          = cfg_lsb[win_idx];
               rxneg_d        = cfg_rxneg[win_idx];
               txneg_d        = cfg_txneg[win_idx];
               div_d          = cfg_div[wi*DIV_W +: DIV_W];
               state_d        = S_LOAD;
            end
         end
         S_LOAD: state_d = S_GO;
         S_GO: begin
            tip_seen_d = 1'b0;
            wd_d       = 3'd0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            // A rising toggle after the engine finished would add a spurious pos_edge.
            div_step   = !(tip_fall && !sclk_q);
            tip_seen_d = tip_seen_q | sh_tip;
            if (tip_fall) begin
               state_d = S_FLUSH;
            end else if (!tip_seen_q && !sh_tip) begin
               if (wd_q == 3'd3) state_d = S_DONE;
               else wd_d = wd_q + 3'd1;
            end
         end
         S_FLUSH: begin
            div_step = sclk_q;
            if (!sclk_q) state_d = S_DONE;
            else if (dcnt_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (div_step) begin
         sclk_d = sclk_q;
         if (dcnt_q == '0) begin
            dcnt_d = div_q;
            sclk_d = ~sclk_q;
            pos_d  = ~sclk_q;
            neg_d  = sclk_q;
         end else begin
            dcnt_d = dcnt_q - DIV_W'(1);
         end
      end

      if (state_d == S_DONE && state_q != S_DONE) rdata_d = sh_p_out;
   end

`ifdef SPI_XFER_AUTO_SS_EN
   logic unused_ss_manual;
   assign unused_ss_manual = ^ss_manual;

   always_comb begin
      ss_n_d = '1;
      if (state_d != S_IDLE) ss_n_d[sel_d] = 1'b0;
   end
`else
   always_comb begin
      ss_n_d = ~ss_manual;
   end
`endif

   always_ff @(posedge clk_shift or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         ptr_q      <= '0;
         gnt_q      <= '0;
         len_q      <= '0;
         lsb_q      <= 1'b0;
         rxneg_q    <= 1'b0;
         txneg_q    <= 1'b0;
         div_q      <= '0;
         dcnt_q     <= '0;
         sclk_q     <= 1'b0;
         pos_q      <= 1'b0;
         neg_q      <= 1'b0;
         tip_q      <= 1'b0;
         tip_seen_q <= 1'b0;
         wd_q       <= '0;
         rdata_q    <= '0;
         ss_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         len_q      <= len_d;
         lsb_q      <= lsb_d;
         rxneg_q    <= rxneg_d;
         txneg_q    <= txneg_d;
         div_q      <= div_d;
         dcnt_q     <= dcnt_d;
         sclk_q     <= sclk_d;
         pos_q      <= pos_d;
         neg_q      <= neg_d;
         tip_q      <= tip_d;
         tip_seen_q <= tip_seen_d;
         wd_q       <= wd_d;
         rdata_q    <= rdata_d;
         ss_n_q     <= ss_n_d;
      end
   end

   assign gnt           = gnt_q;
   assign done          = (state_q == S_DONE) ? gnt_q : '0;
   assign rdata         = rdata_q;
   assign busy          = (state_q != S_IDLE);
   assign ss_n          = ss_n_q;
   assign sh_latch      = (state_q == S_LOAD) ? 4'b0001 : 4'b0000;
   assign sh_byte_sel   = (state_q == S_LOAD) ? 32'h0000_000F : 32'h0;
   assign sh_p_in       = (state_q == S_LOAD) ? wdata[int'(sel_q)*32 +: 32] : 32'h0;
   assign sh_len        = len_q;
   assign sh_lsb        = lsb_q;
   assign sh_rx_negedge = rxneg_q;
   assign sh_tx_negedge = txneg_q;
   assign sh_go         = (state_q == S_GO);
   assign sh_pos_edge   = pos_q;
   assign sh_neg_edge   = neg_q;
   assign s_clk         = sclk_q;
   assign dbg_state     = state_q;

endmodule

// File: doc/spi_xfer_arb.md
Name: spi_xfer_arb

Overview:
- Round-robin arbiter and transfer sequencer that shares one spi_shift engine between NREQ requesters.
- Latches the winner's configuration and write word into the engine, then pulses go.
- Generates s_clk and its pos_edge/neg_edge strobes from a per-requester divider.
- Returns the received word with a one-cycle done pulse.

Parameters:
NREQ, 2, number of requesters (2..8)
DIV_W, 8, width of the sclk divider field

Ports:
clk_shift  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  transfer request per requester, level, held until done
cfg_len  in  NREQ*5  per-requester character length (0 = 32 bits)
cfg_lsb  in  NREQ  per-requester LSB-first
cfg_rxneg  in  NREQ  per-requester rx on negedge
cfg_txneg  in  NREQ  per-requester tx on negedge
cfg_div  in  NREQ*DIV_W  per-requester divider; sclk period = 2*(div+1) clk_shift cycles
wdata  in  NREQ*32  per-requester transmit word
ss_manual  in  NREQ  manual slave-select request (used only without macro)
gnt  out  NREQ  one-hot grant, held LOAD..DONE
done  out  NREQ  one-cycle completion pulse to the granted requester
rdata  out  32  received word, valid from the done cycle until the next DONE
busy  out  1  state != IDLE
ss_n  out  NREQ  active-low slave selects
sh_latch  out  4  to engine latch
sh_byte_sel  out  32  to engine byte_sel
sh_p_in  out  32  to engine p_in
sh_len  out  5  to engine len
sh_lsb, sh_rx_negedge, sh_tx_negedge  out  1 each  to engine
sh_go  out  1  to engine go
sh_pos_edge, sh_neg_edge  out  1 each  edge strobes to engine
s_clk  out  1  serial clock (to pad and engine)
sh_tip  in  1  engine tip
sh_p_out  in  32  engine p_out

Behaviour:
- Reset values (rst_n low, async):
  - State = IDLE; all outputs 0 except ss_n all ones.
  - Round-robin pointer = 0; rdata = 0.
- FSM states: IDLE, LOAD, GO, RUN, FLUSH, DONE.
- IDLE, arbitration:
  - If any req is set, pick the first set bit searching from ptr upward, wrapping around.
  - Register that index as sel, set gnt[sel], and go to LOAD.
  - Set ptr = sel+1 mod NREQ at grant time.
  - A single requester re-requesting is granted again when no other request is pending.
- Config drive: sh_len/lsb/rx_negedge/tx_negedge and the divider reload value are registered from requester sel at grant and held stable LOAD..DONE.
- LOAD (1 cycle): sh_latch = 4'b0001, sh_byte_sel = 32'h0000000F, sh_p_in = wdata[sel]. Then go to GO.
- GO (1 cycle): sh_go = 1. Then go to RUN.
- RUN:
  - Divider counter dcnt loads the divider value on entry and decrements each cycle.
  - At dcnt == 0 it reloads and toggles s_clk.
  - sh_pos_edge = 1 in the cycle s_clk goes 0->1; sh_neg_edge = 1 in the cycle s_clk goes 1->0. Strobes are never simultaneous.
  - Go to FLUSH when sh_tip is seen falling (tip was 1 last cycle, now 0).
- FLUSH:
  - Divider keeps running until the next neg_edge returns s_clk to 0, then go to DONE.
  - If s_clk is already 0, go to DONE immediately.
- DONE (1 cycle):
  - rdata <= sh_p_out; done[sel] = 1; gnt cleared at exit; go to IDLE.
  - A new grant is possible in the cycle after DONE.
- Timing:
  - Idle s_clk = 0 (CPOL 0). Divider is held at reload outside RUN/FLUSH.
  - div = 0 gives s_clk toggling every cycle (period 2).
- Requests:
  - Deasserting req[sel] mid-transfer has no effect; the transfer completes and done still pulses.
  - Requests from other requesters during a transfer wait; they are arbitrated in IDLE only.
- Reset mid-transfer: everything returns to reset values immediately, including s_clk = 0 and ss_n all ones.
- Watchdog: if sh_tip never rises within 2 cycles of GO, the FSM is still in RUN. A RUN-entry watchdog of 4 cycles without tip high forces DONE, with rdata = sh_p_out unchanged.

Optional Feature:
Macro SPI_XFER_AUTO_SS_EN.
- Defined: ss_n[sel] = 0 from LOAD through DONE inclusive, registered; all other ss_n bits = 1. ss_manual is ignored.
- Undefined: ss_n = ~ss_manual, registered with a one-cycle delay and independent of FSM state.

Test Plan:
1. Reset, then req=2'b01, cfg_len=8, div=1, wdata=32'hA5, loopback s_out->s_in:
   - sh_latch=1 and sh_p_in=32'hA5 for 1 cycle, then go.
   - 8 pos_edges each 4 cycles apart.
   - done[0] pulses; rdata[7:0]=8'hA5; s_clk ends at 0.
2. req=2'b11 held continuously from reset: grants alternate 0,1,0,1 over four transfers; each gnt is one-hot; no overlap.
3. cfg_len=0, div=0: exactly 32 pos_edge strobes; s_clk toggles every cycle; done once.
4. rst_n pulled low in RUN after the 3rd pos_edge: in the same cycle s_clk=0, gnt=0, busy=0, ss_n all ones. The next req restarts from LOAD.
5. req[0] dropped in RUN while req[1] is raised: transfer 0 completes with done[0]; requester 1 is granted after IDLE.
6. With SPI_XFER_AUTO_SS_EN, sel=1: ss_n=2'b01 exactly from LOAD to DONE. Without it: ss_n follows ~ss_manual one cycle later.
